// File: rtl/i2c_reg_sequencer.sv
// Wishbone master that drives i2c_master_top through a full single-byte register write or read.
// One access at a time, 3+ clocks each; commands accepted only when idle and no response is pending.
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE     = 16'h0063,
  parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOAD_TXR, S_ISSUE_CR, S_POLL_SR,
    S_CHECK, S_READ_RXR, S_STOP_ERR, S_POLL_BUSY, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [1:0]  phase_q, phase_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        al_q, al_d;
  logic        rxack_q, rxack_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;

  logic        acc_req, acc_we;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat;
  logic        ack;
  logic [7:0]  phase_byte, phase_cr;
  logic [1:0]  last_phase;
  logic [15:0] poll_cnt_inc;

  assign ack          = cyc_q & wb_ack_i;
  assign last_phase   = rw_q ? 2'd3 : 2'd2;
  assign poll_cnt_inc = poll_cnt_q + 16'd1;

  always_comb begin
    phase_byte = 8'h00;
    phase_cr   = 8'h68;
    case (phase_q)
      2'd0: begin phase_byte = {dev_q, 1'b0}; phase_cr = 8'h90; end
      2'd1: begin phase_byte = reg_q;         phase_cr = 8'h10; end
      2'd2: begin
        phase_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
        phase_cr   = rw_q ? 8'h90 : 8'h50;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    al_d       = al_q;
    rxack_d    = rxack_q;
    poll_cnt_d = poll_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    acc_req    = 1'b0;
    acc_we     = 1'b0;
    acc_adr    = 3'd0;
    acc_dat    = 8'h00;

    case (state_q)
      S_INIT: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = {1'b0, init_idx_q};
        acc_dat = (init_idx_q == 2'd0) ? PRESCALE[7:0] :
                  (init_idx_q == 2'd1) ? PRESCALE[15:8] : 8'h80;
        if (ack) begin
          if (init_idx_q == 2'd2) begin
            init_idx_d = 2'd0;
            state_d    = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          dev_d   = cmd_dev_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          phase_d = 2'd0;
          err_d   = 2'd0;
          rdata_d = 8'h00;
          state_d = S_LOAD_TXR;
        end
      end
      S_LOAD_TXR: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = 3'd3;
        acc_dat = phase_byte;
        if (ack) state_d = S_ISSUE_CR;
      end
      S_ISSUE_CR: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = 3'd4;
        acc_dat = phase_cr;
        if (ack) begin
          poll_cnt_d = 16'd0;
          state_d    = S_POLL_SR;
        end
      end
      S_POLL_SR: begin
        acc_req = 1'b1;
        acc_adr = 3'd4;
        if (ack) begin
          poll_cnt_d = poll_cnt_inc;
          al_d       = wb_dat_i[5];
          rxack_d    = wb_dat_i[7];
          if (!wb_dat_i[1]) begin
            state_d = S_CHECK;
          end else if (poll_cnt_inc == POLL_TIMEOUT) begin
            err_d   = 2'd3;
            state_d = S_STOP_ERR;
          end
        end
      end
      S_CHECK: begin
        // Lost arbitration means the core already let go of the bus: no STOP needed.
        if (al_q) begin
          err_d   = 2'd2;
          state_d = S_RESP;
        end else if (rxack_q && phase_q != 2'd3) begin
          err_d   = 2'd1;
          state_d = S_STOP_ERR;
        end else if (phase_q == last_phase) begin
          state_d = rw_q ? S_READ_RXR : S_RESP;
        end else begin
          phase_d = phase_q + 2'd1;
          state_d = (phase_q == 2'd2) ? S_ISSUE_CR : S_LOAD_TXR;
        end
      end
      S_READ_RXR: begin
        acc_req = 1'b1;
        acc_adr = 3'd3;
        if (ack) begin
          rdata_d = wb_dat_i;
          state_d = S_RESP;
        end
      end
      S_STOP_ERR: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = 3'd4;
        acc_dat = 8'h40;
        if (ack) begin
          poll_cnt_d = 16'd0;
          state_d    = (err_q == 2'd3) ? S_RESP : S_POLL_BUSY;
        end
      end
      S_POLL_BUSY: begin
        acc_req = 1'b1;
        acc_adr = 3'd4;
        if (ack) begin
          poll_cnt_d = poll_cnt_inc;
          if (!wb_dat_i[6]) begin
            state_d = S_RESP;
          end else if (poll_cnt_inc == POLL_TIMEOUT) begin
            err_d   = 2'd3;
            state_d = S_STOP_ERR;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Bus outputs are launched from idle and cleared on ack, so every access gets a dead cycle.
  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (ack) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 3'd0;
      dat_d = 8'h00;
    end else if (acc_req && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q    <= S_INIT;
      init_idx_q <= 2'd0;
      phase_q    <= 2'd0;
      rw_q       <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      al_q       <= 1'b0;
      rxack_q    <= 1'b0;
      poll_cnt_q <= 16'd0;
      rdata_q    <= 8'h00;
      err_q      <= 2'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 3'd0;
      dat_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      al_q       <= al_d;
      rxack_q    <= rxack_d;
      poll_cnt_q <= poll_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural i2c_master_top register model plus directed vectors.
module tb_i2c_reg_sequencer;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_ack_i = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.PRESCALE(16'h0063), .POLL_TIMEOUT(16'd16)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // i2c core model: 1-cycle ack, TIP for two SR reads after a CR write, BUSY for two after STO.
  logic [7:0]  m_rdata = 8'h00;
  logic [8:0]  m_nack  = 9'h100;
  logic        m_al    = 1'b0;
  logic        m_stuck = 1'b0;
  logic [7:0]  m_txr   = 8'h00;
  logic        m_rxack = 1'b0;
  int          tip_cnt = 0;
  int          busy_cnt = 0;
  int          sr_reads = 0;
  logic [10:0] wr_log[$];
  logic [7:0]  txr_log[$];
  logic [7:0]  cr_log[$];
  logic        seen_rv = 1'b0;

  always @(posedge clk) begin
    if (wb_rst_i) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= 8'h00;
      tip_cnt  = 0;
      busy_cnt = 0;
      m_rxack  = 1'b0;
    end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      wb_ack_i <= 1'b1;
      if (wb_we_o) begin
        wr_log.push_back({wb_adr_o, wb_dat_o});
        if (wb_adr_o == 3'd3) begin
          txr_log.push_back(wb_dat_o);
          m_txr = wb_dat_o;
        end else if (wb_adr_o == 3'd4) begin
          cr_log.push_back(wb_dat_o);
          if (wb_dat_o == 8'h40) begin
            busy_cnt = 2;
            tip_cnt  = 0;
          end else begin
            tip_cnt = 2;
            m_rxack = wb_dat_o[5] || (wb_dat_o[4] && ({1'b0, m_txr} == m_nack));
          end
        end
      end else if (wb_adr_o == 3'd4) begin
        sr_reads = sr_reads + 1;
        wb_dat_i <= {m_rxack, (busy_cnt > 0), m_al, 3'b000, (m_stuck || tip_cnt > 0), 1'b0};
        if (tip_cnt > 0) tip_cnt = tip_cnt - 1;
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      end else begin
        wb_dat_i <= m_rdata;
      end
    end else begin
      wb_ack_i <= 1'b0;
    end
  end

  always @(negedge clk) if (rsp_valid) seen_rv = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic init_check(input string tag);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_nwr"}, wr_log.size(), 3);
    chk({tag, "_wr0"}, wr_log[0], {3'd0, 8'h63});
    chk({tag, "_wr1"}, wr_log[1], {3'd1, 8'h00});
    chk({tag, "_wr2"}, wr_log[2], {3'd2, 8'h80});
  endtask

  task automatic send_cmd(input string tag, input logic rw, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_busy_ready"}, cmd_ready, 0);
  endtask

  task automatic do_cmd(input string tag, input logic rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [7:0] wd,
                        output logic [1:0] err, output logic [7:0] rd);
    int n = 0;
    send_cmd(tag, rw, dev, rg, wd);
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    err = rsp_err;
    rd  = rsp_rdata;
    if (rsp_ready) begin
      @(negedge clk);
      chk({tag, "_ret_idle"}, {rsp_valid, cmd_ready}, 2'b01);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  rg, wd, srd;
    logic [8:0]  nack;
    logic        al;
    logic [1:0]  err;
    logic [7:0]  rdata;
    int          ntxr;
    logic [31:0] txr;
    int          ncr;
    logic [39:0] cr;
    int          srr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0] e;
    logic [7:0] r;
    int n;
    int stable;

    vecs[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 9'h100, 1'b0, 2'd0, 8'h00, 3, 32'hA012A500, 3, 40'h9010500000, 9};
    vecs[1] = '{1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 9'h100, 1'b0, 2'd0, 8'h5C, 3, 32'hA034A100, 4, 40'h9010906800, 12};
    vecs[2] = '{1'b0, 7'h11, 8'h12, 8'hA5, 8'h00, 9'h022, 1'b0, 2'd1, 8'h00, 1, 32'h22000000, 2, 40'h9040000000, 6};
    vecs[3] = '{1'b1, 7'h11, 8'h34, 8'h00, 8'h5C, 9'h022, 1'b0, 2'd1, 8'h00, 1, 32'h22000000, 2, 40'h9040000000, 6};
    vecs[4] = '{1'b0, 7'h50, 8'h77, 8'hA5, 8'h00, 9'h077, 1'b0, 2'd1, 8'h00, 2, 32'hA0770000, 3, 40'h9010400000, 9};
    vecs[5] = '{1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 9'h0A1, 1'b0, 2'd1, 8'h00, 3, 32'hA034A100, 4, 40'h9010904000, 12};
    vecs[6] = '{1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 9'h100, 1'b1, 2'd2, 8'h00, 1, 32'hA0000000, 1, 40'h9000000000, 3};
    vecs[7] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 8'h3C, 9'h100, 1'b0, 2'd0, 8'h3C, 3, 32'hFEFFFF00, 4, 40'h9010906800, 12};
    vecs[8] = '{1'b0, 7'h00, 8'h00, 8'hFF, 8'h00, 9'h100, 1'b0, 2'd0, 8'h00, 3, 32'h0000FF00, 3, 40'h9010500000, 9};
    vecs[9] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 9'h0A5, 1'b0, 2'd1, 8'h00, 3, 32'hA012A500, 4, 40'h9010504000, 12};

    wb_rst_i = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev_addr = 7'd0; cmd_reg_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, cmd_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
    wr_log.delete();
    wb_rst_i = 1'b0;
    init_check("init");

    for (int i = 0; i < 10; i++) begin
      m_rdata = vecs[i].srd; m_nack = vecs[i].nack; m_al = vecs[i].al; m_stuck = 1'b0;
      txr_log.delete(); cr_log.delete(); sr_reads = 0;
      do_cmd($sformatf("v%0d", i), vecs[i].rw, vecs[i].dev, vecs[i].rg, vecs[i].wd, e, r);
      chk($sformatf("v%0d_err", i), e, vecs[i].err);
      chk($sformatf("v%0d_rdata", i), r, vecs[i].rdata);
      chk($sformatf("v%0d_ntxr", i), txr_log.size(), vecs[i].ntxr);
      for (int j = 0; j < vecs[i].ntxr; j++)
        chk($sformatf("v%0d_txr%0d", i, j), txr_log[j], vecs[i].txr[31-8*j -: 8]);
      chk($sformatf("v%0d_ncr", i), cr_log.size(), vecs[i].ncr);
      for (int j = 0; j < vecs[i].ncr; j++)
        chk($sformatf("v%0d_cr%0d", i, j), cr_log[j], vecs[i].cr[39-8*j -: 8]);
      chk($sformatf("v%0d_sr_reads", i), sr_reads, vecs[i].srr);
    end

    // TIP stuck high: poll limit, then STO and a response held under back-pressure.
    m_al = 1'b0; m_nack = 9'h100; m_stuck = 1'b1;
    txr_log.delete(); cr_log.delete(); sr_reads = 0;
    rsp_ready = 1'b0;
    do_cmd("to", 1'b0, 7'h50, 8'h12, 8'hA5, e, r);
    chk("to_err", e, 2'd3);
    chk("to_rdata", r, 8'h00);
    chk("to_sr_reads", sr_reads, 16);
    chk("to_ncr", cr_log.size(), 2);
    chk("to_cr_sto", cr_log[1], 8'h40);
    chk("to_ntxr", txr_log.size(), 1);
    stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid && rsp_err == 2'd3 && rsp_rdata == 8'h00) stable++;
    end
    chk("to_hold", stable, 10);
    chk("to_hold_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("to_release", {rsp_valid, cmd_ready}, 2'b01);

    // Reset in the middle of a read's SR poll.
    sr_reads = 0;
    send_cmd("rst", 1'b1, 7'h50, 8'h34, 8'h00);
    n = 0;
    while (sr_reads < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_in_poll", sr_reads >= 3, 1);
    seen_rv = 1'b0;
    wb_rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
    repeat (2) @(negedge clk);
    wr_log.delete();
    m_stuck = 1'b0;
    wb_rst_i = 1'b0;
    init_check("reinit");
    chk("rst_no_rsp", seen_rv, 0);
    txr_log.delete(); cr_log.delete();
    do_cmd("post", 1'b0, 7'h50, 8'h12, 8'hA5, e, r);
    chk("post_err", e, 2'd0);
    chk("post_ntxr", txr_log.size(), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
